branch_predictor: RTL and testbench

- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Sits in Fetch. It predicts next-PC for each fetched PC and is trained by the update stream from branch_resolver in Execute.
- Prediction is registered: lookup at cycle N gives the result at cycle N+1.

---
 rtl/core_pkg.sv | 21 ++
 rtl/sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 103 ++++++++++
 tb/tb_branch_predictor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Definitions shared by the fetch-side predictor and the execute-side branch
// resolver: address width, direction-counter encodings and the update bundle.
package core_pkg;

  localparam int XLEN = 32;

  // 2-bit direction counter encodings
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Resolved-branch record produced by branch_resolver
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } upd_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating counter: up counts toward ST,
// down counts toward SNT, and neither end wraps.
module sat_counter2
  import core_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] next
);

  always_comb begin
    next = ctr;
    if (up) begin
      if (ctr != ST) next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit direction counter per entry. A lookup is
// registered (result one edge later) and trained by the resolver's update stream.
module branch_predictor
  import core_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic            fetch_stall,
  input  logic            flush,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // Interface semantics: a lookup is accepted on any edge with lookup_valid=1,
  // fetch_stall=0 and flush=0; pred_* then describes it until the next accepted
  // edge. Updates have no ready: every edge with upd_valid=1 trains the table.

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, l_taken, u_hit;
  logic [1:0]       ctr_next;
  logic             unused;

  assign l_idx   = lookup_pc[IDX_W+1:2];
  assign l_tag   = lookup_pc[XLEN-1:IDX_W+2];
  assign u_idx   = upd_pc[IDX_W+1:2];
  assign u_tag   = upd_pc[XLEN-1:IDX_W+2];
  assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign l_taken = l_hit && ctr_q[l_idx][1];
  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign unused  = ^{lookup_pc[1:0], upd_pc[1:0]};

  sat_counter2 u_ctr (
    .ctr  (ctr_q[u_idx]),
    .up   (upd_taken),
    .next (ctr_next)
  );

  // Valid bits and counters: the only table state that reset must clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_next;
      end else if (upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= WT;
      end
    end
  end

  // Tag rewrite on a hit is harmless: it stores the same tag again
  always_ff @(posedge clock) begin
    if (upd_valid && upd_taken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
    end
  end

  // Prediction registers; flush outranks stall
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (flush) begin
      pred_valid <= 1'b0;
      pred_hit   <= 1'b0;
      pred_taken <= 1'b0;
    end else if (!fetch_stall) begin
      if (lookup_valid) begin
        pred_valid  <= 1'b1;
        pred_hit    <= l_hit;
        pred_taken  <= l_taken;
        pred_target <= l_taken ? target_q[l_idx] : lookup_pc + XLEN'(4);
      end else begin
        pred_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then random
// traffic, each cycle compared against a table model indexed by whole PCs.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic        lookup_valid, fetch_stall, flush;
  logic [31:0] lookup_pc;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc, upd_target;

  int n_checks = 0;
  int n_errors = 0;

  // expected {valid, hit, taken, target} after each edge
  logic [34:0] exp_q[$];

  // reference model: a 16-slot table remembering the full PC of each owner
  bit          m_valid [16];
  logic [31:0] m_owner [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic        mv, mh, mt;
  logic [31:0] mtgt;

  branch_predictor dut (
    .clock        (clock),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .fetch_stall  (fetch_stall),
    .flush        (flush),
    .pred_valid   (pred_valid),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int s = slot(pc);
    return m_valid[s] && ((pc >> 6) == (m_owner[s] >> 6));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    mv = 0; mh = 0; mt = 0; mtgt = 0;
  endtask

  task automatic drive_idle();
    lookup_valid = 0; lookup_pc = 0; fetch_stall = 0; flush = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
  endtask

  // one clock: drive inputs, advance the model, compare after the edge
  task automatic step(input bit lv, input logic [31:0] lpc, input bit stall, input bit fl,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt);
    logic [34:0] e;
    int          s;
    @(negedge clock);
    lookup_valid = lv; lookup_pc = lpc; fetch_stall = stall; flush = fl;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    // prediction sees the table as it stood before this edge's update
    if (fl) begin
      mv = 0; mh = 0; mt = 0;
    end else if (!stall) begin
      if (lv) begin
        s    = slot(lpc);
        mv   = 1;
        mh   = model_hit(lpc);
        mt   = mh && (m_ctr[s] >= 2);
        mtgt = mt ? m_tgt[s] : lpc + 32'd4;
      end else begin
        mv = 0;
      end
    end
    if (uv) begin
      s = slot(upc);
      if (model_hit(upc)) begin
        m_ctr[s] = ut ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
        if (ut) m_tgt[s] = utgt;
      end else if (ut) begin
        m_valid[s] = 1; m_owner[s] = upc; m_tgt[s] = utgt; m_ctr[s] = 2;
      end
    end
    exp_q.push_back({mv, mh, mt, mtgt});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("pred_valid", 64'(pred_valid), 64'(e[34]));
    check("pred_hit", 64'(pred_hit), 64'(e[33]));
    check("pred_taken", 64'(pred_taken), 64'(e[32]));
    check("pred_target", 64'(pred_target), 64'(e[31:0]));
  endtask

  task automatic look(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    step(0, 0, 0, 0, 1, pc, t, tgt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(pred_valid), 0);
    check({tag, "_hit"}, 64'(pred_hit), 0);
    check({tag, "_taken"}, 64'(pred_taken), 0);
    check({tag, "_target"}, 64'(pred_target), 0);
  endtask

  initial begin
    logic [31:0] rpc;
    drive_idle();
    model_reset();
    reset = 0;
    repeat (2) @(posedge clock);
    #1 check_zero("reset");
    @(negedge clock);
    reset = 1;

    // cold lookup misses and predicts fall-through
    look(32'h100);
    check("cold_target", 64'(pred_target), 64'h104);
    check("cold_hit", 64'(pred_hit), 0);

    // allocate, then train down to strongly not-taken and past it
    upd(32'h100, 1, 32'h200);
    look(32'h100);
    check("alloc_target", 64'(pred_target), 64'h200);
    check("alloc_taken", 64'(pred_taken), 1);
    repeat (3) upd(32'h100, 0, 0);
    look(32'h100);
    check("snt_taken", 64'(pred_taken), 0);
    check("snt_target", 64'(pred_target), 64'h104);
    upd(32'h100, 0, 0);
    upd(32'h100, 1, 32'h200);
    look(32'h100);
    check("sat_floor_taken", 64'(pred_taken), 0);
    check("sat_floor_hit", 64'(pred_hit), 1);

    // alias at slot 0: 0x140 evicts 0x100
    upd(32'h140, 1, 32'h300);
    look(32'h100);
    check("alias_old_hit", 64'(pred_hit), 0);
    look(32'h140);
    check("alias_new_target", 64'(pred_target), 64'h300);

    // same-edge lookup and allocate of a fresh slot: read before write
    step(1, 32'h104, 0, 0, 1, 32'h104, 1, 32'h200);
    check("rbw_hit", 64'(pred_hit), 0);
    look(32'h104);
    check("rbw_next_target", 64'(pred_target), 64'h200);

    // stall freezes outputs, flush overrides stall
    look(32'h140);
    step(1, 32'h104, 1, 0, 0, 0, 0, 0);
    step(1, 32'h200, 1, 0, 0, 0, 0, 0);
    step(1, 32'h300, 1, 0, 0, 0, 0, 0);
    check("stall_target", 64'(pred_target), 64'h300);
    step(1, 32'h104, 1, 1, 0, 0, 0, 0);
    check("flush_valid", 64'(pred_valid), 0);

    // asynchronous reset between edges
    look(32'h100);
    @(negedge clock);
    drive_idle();
    #2 reset = 0;
    #1 check_zero("async_reset");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    #2 reset = 1;
    upd(32'h10, 1, 32'h40);
    look(32'h100);
    check("post_reset_hit", 64'(pred_hit), 0);
    check("post_reset_target", 64'(pred_target), 64'h104);

    // random traffic over a small PC pool so slots collide and hit often
    for (int i = 0; i < 400; i++) begin
      rpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      step($urandom_range(0, 3) != 0, rpc,
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2),
           $urandom_range(0, 2) != 0, $urandom());
    end
    // wrap of the fall-through address
    look(32'hFFFF_FFFC);
    check("wrap_target", 64'(pred_target), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
